mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait for m_valid.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have ports i_req in 1 (fetch request), i_addr in AW (fetch address), i_kill in 1 (pipeline flush, discard fetch in flight).
REQ-007 SHALL have ports i_rdata out DW (fetched instruction) and i_ack out 1 (fetch complete, one-cycle pulse).
REQ-008 SHALL have ports d_req in 1 (data request), d_we in 1 (1=store, 0=load), d_addr in AW, d_wdata in DW.
REQ-009 SHALL have ports d_rdata out DW (load data) and d_ack out 1 (data access complete, one-cycle pulse).
REQ-010 SHALL have ports m_req out 1, m_we out 1, m_addr out AW, m_wdata out DW (single-port memory command).
REQ-011 SHALL have ports m_rdata in DW and m_valid in 1 (memory response, one cycle, for reads and writes).
REQ-012 SHALL have ports stall out 1 (CPU pipeline freeze) and err out 1 (sticky timeout flag).

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, WAIT, RESP.
REQ-014 IDLE: no request pending -> stay; any request pending -> GRANT, latching the winner's command into output registers.
REQ-015 GRANT SHALL drive m_req=1 for exactly one cycle, then move to WAIT.
REQ-016 WAIT SHALL keep m_req=0; on m_valid, latch m_rdata and move to RESP; TIMEOUT cycles without m_valid -> set err, return to IDLE, no ack.
REQ-017 RESP SHALL pulse the winner's ack for one cycle with its rdata valid, then return to IDLE.
REQ-018 Arbitration SHALL be round-robin via a last_grant flag: both pending -> grant the port not granted last; only one pending -> grant it.
REQ-019 Requesters SHALL hold req and command stable until ack; the arbiter samples the command only in IDLE.
REQ-020 i_kill asserted while the fetch is in GRANT/WAIT/RESP SHALL suppress i_ack for that fetch; the memory transaction still completes.
REQ-021 i_kill and d_ack in the same cycle SHALL not affect the data port.
REQ-022 i_rdata/d_rdata SHALL hold their last value until the next ack on that port.
REQ-023 Fetch latency SHALL be exactly 3+L cycles from i_req sampled in IDLE to i_ack, for memory latency L>=1 (m_valid L cycles after m_req).
REQ-024 A write SHALL return d_ack on m_valid and leave d_rdata unchanged.
REQ-025 stall SHALL be combinational: (i_req & ~i_ack) | (d_req & ~d_ack).
REQ-026 The timeout counter SHALL be 4 bits, clear on entry to WAIT, and never wrap.
REQ-027 m_valid outside WAIT SHALL be ignored.

Reset
REQ-028 rst SHALL force state IDLE, last_grant=instruction (data wins the first tie), timeout counter 0, err 0.
REQ-029 rst SHALL force m_req=0, m_we=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0.
REQ-030 rst mid-transaction SHALL drop the transaction without an ack; a late m_valid after reset is ignored.

Structure
REQ-031 FSM state encoding and the port-id constants (PORT_I, PORT_D) SHALL reside in a shared package mem_pkg.
REQ-032 The timeout counter SHALL be one sub-module, wdog_cnt; all other logic SHALL be flat in mem_arbiter.

Verification
REQ-033 i_req with i_addr=0x40 and memory L=1 returning 0x8C010004 -> m_req pulse with m_addr=0x40, i_ack 4 cycles after i_req sampled, i_rdata=0x8C010004.
REQ-034 i_req and d_req together from reset -> data granted first, then instruction; over 4 back-to-back pairs the grants alternate D,I,D,I.
REQ-035 d_req with d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF, d_ack pulse, d_rdata unchanged.
REQ-036 Fetch in WAIT with i_kill pulsed -> no i_ack; a subsequent d_req is served normally.
REQ-037 Memory never asserts m_valid -> err=1 after 15 WAIT cycles, FSM back in IDLE, stall stays high while the request persists.
REQ-038 rst asserted in WAIT, then m_valid -> all outputs at reset values and no ack.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared state encoding and port identifiers for the instruction/data memory arbiter.
// Declarations only, no logic; no timing or flow-control behaviour of its own.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int WDOG_W = 4;

endpackage

// File: rtl/wdog_cnt.sv
// Watchdog for the memory response: counts cycles spent waiting and flags the last allowed one.
// Latency: expired is combinational from the registered count; the count updates every enabled cycle.
// Backpressure: none; it saturates at all-ones instead of wrapping.
module wdog_cnt
    import mem_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 1);
    localparam logic [WDOG_W-1:0] ONE  = WDOG_W'(1);

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch port and a data port.
// Latency: ack arrives 3+L cycles after the request is sampled in IDLE (L = memory latency).
// Backpressure: requesters hold req until ack; stall freezes the pipeline meanwhile.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_kill,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_valid,
    output logic          stall,
    output logic          err
);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          owner;
    logic          last_grant;
    logic          killed;
    logic          win;
    logic          i_pend;
    logic          d_pend;
    logic          timeout;
    logic [DW-1:0] rdata_q;

    // A port whose ack is showing this cycle is finished, even though its req is still high.
    assign i_pend = i_req & ~i_ack;
    assign d_pend = d_req & ~d_ack;
    assign stall  = i_pend | d_pend;

    always_comb begin
        win = PORT_I;
        if (i_pend && d_pend) begin
            win = ~last_grant;
        end else if (d_pend) begin
            win = PORT_D;
        end
    end

    wdog_cnt #(
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == GRANT),
        .en      ((state == WAIT) && !m_valid),
        .expired (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_pend || d_pend) state_nxt = GRANT;
            GRANT:   state_nxt = WAIT;
            WAIT: begin
                if (m_valid) begin
                    state_nxt = RESP;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            rdata_q    <= '0;
            err        <= 1'b0;
            owner      <= PORT_I;
            last_grant <= PORT_I;
            killed     <= 1'b0;
        end else begin
            m_req <= 1'b0;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_pend || d_pend) begin
                        owner      <= win;
                        last_grant <= win;
                        killed     <= 1'b0;
                        m_req      <= 1'b1;
                        if (win == PORT_D) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            m_we    <= 1'b0;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                        end
                    end
                end
                GRANT: begin
                    if (i_kill && (owner == PORT_I)) killed <= 1'b1;
                end
                WAIT: begin
                    if (i_kill && (owner == PORT_I)) killed <= 1'b1;
                    if (m_valid) begin
                        rdata_q <= m_rdata;
                    end else if (timeout) begin
                        err <= 1'b1;
                    end
                end
                RESP: begin
                    if (owner == PORT_D) begin
                        d_ack <= 1'b1;
                        if (!m_we) d_rdata <= rdata_q;
                    end else if (!(killed || i_kill)) begin
                        // A flushed fetch still drained the memory but is never acknowledged.
                        i_ack   <= 1'b1;
                        i_rdata <= rdata_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_kill, i_ack;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_valid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        stall, err;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_valid(m_valid),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int          cyc = 0;
    bit          out_vld = 0, out_port = 0, out_kill = 0, out_we = 0;
    int          out_c0 = 0, out_L = 0;
    logic [31:0] out_addr = 0, out_wdata = 0;
    bit          lg = 0;
    logic [31:0] exp_ird = 0, exp_drd = 0;
    logic        exp_err = 0;
    logic        sv_iack = 0, sv_dack = 0;
    int          resp_cnt = 0;
    bit          mute = 0, spur = 0;
    int          lat_next = 1;
    logic [31:0] r_addr = 0, r_wd = 0;
    logic        r_we = 0;
    logic [31:0] ref_dmem [logic [31:0]];
    logic [31:0] resp_mem [logic [31:0]];
    int          gq[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ifetch_data(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C010004;
        return {~a[15:0], a[15:0]};
    endfunction

    // One cycle: all observation happens at the falling edge, then the caller drives inputs.
    task automatic tick();
        logic pi, pd, e_iack, e_dack, ep, ap;
        @(negedge clk);
        i_kill = 1'b0;
        cyc++;
        pi = i_req & ~sv_iack;
        pd = d_req & ~sv_dack;
        sv_iack = i_ack;
        sv_dack = d_ack;
        chk("stall", stall, (i_req & ~i_ack) | (d_req & ~d_ack));

        e_iack = 0;
        e_dack = 0;
        if (out_vld && out_L > 0 && cyc == out_c0 + out_L + 2) begin
            out_vld = 0;
            if (!out_port) begin
                e_iack = !out_kill;
                if (!out_kill) exp_ird = ifetch_data(out_addr);
            end else begin
                e_dack = 1;
                if (out_we) ref_dmem[out_addr] = out_wdata;
                else exp_drd = ref_dmem.exists(out_addr) ? ref_dmem[out_addr] : ~out_addr;
            end
        end
        if (out_vld && out_L == 0 && cyc == out_c0 + TMO + 1) begin
            out_vld = 0;
            exp_err = 1;
        end
        chk("i_ack", i_ack, e_iack);
        chk("d_ack", d_ack, e_dack);
        chk("i_rdata", i_rdata, exp_ird);
        chk("d_rdata", d_rdata, exp_drd);
        chk("err", err, exp_err);

        m_valid = 1'b0;
        m_rdata = $urandom;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                m_valid = 1'b1;
                if (r_we) resp_mem[r_addr] = r_wd;
                else if (r_addr < 32'h100) m_rdata = ifetch_data(r_addr);
                else m_rdata = resp_mem.exists(r_addr) ? resp_mem[r_addr] : ~r_addr;
            end
        end

        if (m_req) begin
            chk("grant_idle", {31'd0, out_vld}, 0);
            chk("grant_pend", pi | pd, 1);
            ep = (pi && pd) ? ~lg : pd;
            ap = (m_addr >= 32'h100);
            chk("grant_port", ap, ep);
            lg = ep;
            gq.push_back(int'(ap));
            chk("m_addr", m_addr, ep ? d_addr : i_addr);
            chk("m_we", m_we, ep ? d_we : 1'b0);
            if (ep && d_we) chk("m_wdata", m_wdata, d_wdata);
            out_vld   = 1;
            out_port  = ep;
            out_c0    = cyc;
            out_L     = mute ? 0 : lat_next;
            out_kill  = 0;
            out_we    = ep & d_we;
            out_addr  = ep ? d_addr : i_addr;
            out_wdata = d_wdata;
            if (!mute) begin
                resp_cnt = lat_next;
                r_addr   = m_addr;
                r_we     = m_we;
                r_wd     = m_wdata;
            end
        end else if (spur && !out_vld && resp_cnt == 0 && $urandom_range(0, 15) == 0) begin
            m_valid = 1'b1;
        end
    endtask

    task automatic kill_now();
        i_kill = 1'b1;
        if (out_vld && !out_port) out_kill = 1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_m_req", m_req, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        i_req = 0; d_req = 0; i_kill = 0;
        out_vld = 0; exp_err = 0; exp_ird = 0; exp_drd = 0; lg = 0;
        repeat (n) tick();
        chk_reset_outs();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input bit port, input int maxc, output int at);
        at = -1;
        for (int k = 0; k < maxc; k++) begin
            tick();
            if (port ? d_ack : i_ack) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int at, t0, n_iack, i_wait, d_wait;
        logic [31:0] drd_before;
        rst = 1'b1;
        i_req = 0; i_addr = 0; i_kill = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_valid = 0; m_rdata = 0;
        do_reset(3);

        // Single fetch, memory latency 1.
        lat_next = 1;
        i_addr = 32'h40; i_req = 1;
        t0 = cyc;
        wait_ack(0, 20, at);
        i_req = 0;
        chk("fetch_lat", at - t0, 4);
        chk("fetch_data", i_rdata, 32'h8C010004);
        repeat (3) tick();

        // Simultaneous requests alternate, data first after reset.
        do_reset(2);
        gq.delete();
        i_addr = 32'h8; d_addr = 32'h104; d_we = 0;
        i_req = 1; d_req = 1;
        for (int k = 0; k < 200 && gq.size() < 8; k++) begin
            tick();
            if (i_ack) i_addr = i_addr + 4;
            if (d_ack) d_addr = d_addr + 4;
        end
        i_req = 0; d_req = 0;
        repeat (10) tick();
        for (int k = 0; k < 8; k++)
            chk("rr_order", (k < gq.size()) ? gq[k] : 2, (k % 2 == 0) ? 1 : 0);

        // Store leaves d_rdata alone; a load reads it back.
        lat_next = 2;
        drd_before = exp_drd;
        d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_req = 1;
        wait_ack(1, 20, at);
        d_req = 0;
        chk("st_ack", at >= 0, 1);
        chk("st_rdata_hold", d_rdata, drd_before);
        tick();
        d_we = 0; d_req = 1;
        wait_ack(1, 20, at);
        d_req = 0;
        chk("ld_back", d_rdata, 32'hDEADBEEF);
        repeat (2) tick();

        // Flushed fetch gets no ack; the data port is unaffected.
        lat_next = 3;
        i_addr = 32'h80; i_req = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_vld) break;
        end
        tick();
        kill_now();
        i_req = 0;
        d_we = 0; d_addr = 32'h108; d_req = 1;
        n_iack = 0;
        at = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (i_ack) n_iack++;
            if (d_ack) begin
                at = cyc;
                break;
            end
        end
        d_req = 0;
        chk("kill_no_iack", n_iack, 0);
        chk("kill_d_served", at >= 0, 1);
        repeat (3) tick();

        // Silent memory: sticky error, back to IDLE, stall persists.
        mute = 1;
        i_addr = 32'h44; i_req = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (err) break;
        end
        chk("tmo_err", err, 1);
        chk("tmo_stall", stall, 1);
        tick();
        chk("tmo_regrant", m_req, 1);
        i_req = 0;
        repeat (20) tick();
        chk("tmo_err_sticky", err, 1);
        mute = 0;
        do_reset(2);

        // Reset in WAIT, memory answers afterwards.
        lat_next = 3;
        i_addr = 32'h48; i_req = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_vld) break;
        end
        tick();
        do_reset(1);
        repeat (6) tick();
        chk_reset_outs();

        // Random traffic.
        spur = 1;
        i_wait = 0;
        d_wait = 0;
        for (int n = 0; n < 2500; n++) begin
            tick();
            if (i_ack) i_wait = 0;
            if (d_ack) d_wait = 0;
            if (out_vld && $urandom_range(0, 9) == 0) begin
                if (!out_port) begin
                    i_req = 0;
                    i_wait = 0;
                end
                kill_now();
            end
            if (i_req && i_ack) i_req = 0;
            if (!i_req && $urandom_range(0, 3) == 0) begin
                i_addr = $urandom_range(0, 63) * 4;
                i_req = 1;
            end
            if (d_req && d_ack) d_req = 0;
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_addr = 32'h100 + $urandom_range(0, 15) * 4;
                d_we = $urandom_range(0, 1);
                d_wdata = $urandom;
                d_req = 1;
            end
            lat_next = $urandom_range(1, 4);
            i_wait = i_req ? i_wait + 1 : 0;
            d_wait = d_req ? d_wait + 1 : 0;
            chk("i_hang", i_wait > 80, 0);
            chk("d_hang", d_wait > 80, 0);
        end
        i_req = 0;
        d_req = 0;
        spur = 0;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
